// File: rtl/ss_ctrl.sv
// ss_ctrl: shadow-stack commit controller with a two-lane event queue and violation FSM.
// Optional feature: define SS_CTRL_UNDERFLOW_TRAP_EN to trap a ret seen on an empty stack.
module ss_ctrl #(
  parameter int DATA_W = 64,
  parameter int QDEPTH = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [1:0]          evt_valid,
  input  logic [1:0]          evt_is_call,
  input  logic [2*DATA_W-1:0] evt_addr,
  output logic                evt_ready,
  output logic                ss_push,
  output logic                ss_pop,
  output logic [DATA_W-1:0]   ss_data,
  input  logic [DATA_W-1:0]   ss_top,
  input  logic                ss_empty,
  input  logic                ss_full,
  input  logic                ss_usable,
  output logic                o_violation,
  output logic [DATA_W-1:0]   o_viol_addr,
  output logic [DATA_W-1:0]   o_viol_exp,
  input  logic                clr_violation,
  output logic [7:0]          o_viol_cnt,
  output logic                o_busy
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  typedef enum logic {RUN, VIOL} state_t;

  state_t state;

  logic              q_call [QDEPTH];
  logic [DATA_W-1:0] q_addr [QDEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       free_n;

  logic              enq0;
  logic              enq1;
  logic [1:0]        n_enq;
  logic              deq;
  logic              head_call;
  logic [DATA_W-1:0] head_addr;
  logic [DATA_W-1:0] addr0;
  logic [DATA_W-1:0] addr1;
  logic              mismatch;
  logic              underflow;
  logic              trap;

  // The full flag is informational only; the stack counts past its depth.
  logic              unused_full;
  assign unused_full = ss_full;

  assign addr0     = evt_addr[DATA_W-1:0];
  assign addr1     = evt_addr[2*DATA_W-1:DATA_W];
  assign free_n    = (AW+1)'(QDEPTH) - count;
  assign evt_ready = (state == RUN) && (free_n >= (AW+1)'(2));
  assign enq0      = evt_ready & evt_valid[0];
  assign enq1      = evt_ready & evt_valid[1];
  assign n_enq     = {1'b0, enq0} + {1'b0, enq1};
  assign head_call = q_call[rd_ptr];
  assign head_addr = q_addr[rd_ptr];
  assign deq       = rstn && (state == RUN) && (count != '0);
  assign trap      = mismatch | underflow;
  assign o_busy    = (count != '0) || (state != RUN);

  // Decode the head event into a stack command and detect a violation.
  always_comb begin
    ss_push   = 1'b0;
    ss_pop    = 1'b0;
    mismatch  = 1'b0;
    underflow = 1'b0;
    if (deq) begin
      if (head_call) begin
        ss_push = 1'b1;
      end else if (ss_empty) begin
`ifdef SS_CTRL_UNDERFLOW_TRAP_EN
        underflow = ss_usable;
`else
        underflow = 1'b0;
`endif
      end else if (!ss_usable) begin
        ss_pop = 1'b1;
      end else begin
        ss_pop   = 1'b1;
        mismatch = (ss_top != head_addr);
      end
    end
  end

  assign ss_data = ss_push ? head_addr : '0;

  // Event queue storage, pointers and net occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_call[i] <= 1'b0;
        q_addr[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq0) begin
        q_call[wr_ptr] <= evt_is_call[0];
        q_addr[wr_ptr] <= addr0;
      end
      if (enq1) begin
        q_call[wr_ptr + AW'(enq0)] <= evt_is_call[1];
        q_addr[wr_ptr + AW'(enq0)] <= addr1;
      end
      wr_ptr <= wr_ptr + AW'(n_enq);
      rd_ptr <= rd_ptr + AW'(deq);
      count  <= count + (AW+1)'(n_enq) - (AW+1)'(deq);
    end
  end

  // RUN/VIOL state machine with the latched alarm details.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= RUN;
      o_violation <= 1'b0;
      o_viol_addr <= '0;
      o_viol_exp  <= '0;
      o_viol_cnt  <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (trap) begin
            state       <= VIOL;
            o_violation <= 1'b1;
            o_viol_addr <= head_addr;
            o_viol_exp  <= mismatch ? ss_top : '0;
            if (o_viol_cnt != 8'hff) begin
              o_viol_cnt <= o_viol_cnt + 8'd1;
            end
          end
        end
        VIOL: begin
          if (clr_violation) begin
            state       <= RUN;
            o_violation <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ss_ctrl.sv
// tb_ss_ctrl: randomized and directed bench for ss_ctrl.
// Stack environment and controller reference model live here.
module tb_ss_ctrl;

  localparam int DW     = 64;
  localparam int QDEPTH = 4;
  localparam int STORE  = 4;

  logic          clk;
  logic          rstn;
  logic [1:0]    evt_valid;
  logic [1:0]    evt_is_call;
  logic [DW-1:0] a0_in;
  logic [DW-1:0] a1_in;
  logic          evt_ready;
  logic          ss_push;
  logic          ss_pop;
  logic [DW-1:0] ss_data;
  logic [DW-1:0] ss_top;
  logic          ss_empty;
  logic          ss_full;
  logic          ss_usable;
  logic          o_violation;
  logic [DW-1:0] o_viol_addr;
  logic [DW-1:0] o_viol_exp;
  logic          clr_violation;
  logic [7:0]    o_viol_cnt;
  logic          o_busy;

  ss_ctrl #(.DATA_W(DW), .QDEPTH(QDEPTH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .evt_valid    (evt_valid),
    .evt_is_call  (evt_is_call),
    .evt_addr     ({a1_in, a0_in}),
    .evt_ready    (evt_ready),
    .ss_push      (ss_push),
    .ss_pop       (ss_pop),
    .ss_data      (ss_data),
    .ss_top       (ss_top),
    .ss_empty     (ss_empty),
    .ss_full      (ss_full),
    .ss_usable    (ss_usable),
    .o_violation  (o_violation),
    .o_viol_addr  (o_viol_addr),
    .o_viol_exp   (o_viol_exp),
    .clr_violation(clr_violation),
    .o_viol_cnt   (o_viol_cnt),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External shadow stack: STORE slots, count may run past them.
  logic [DW-1:0] st [STORE];
  int            sc;
  bit            nouse;

  assign ss_empty  = nouse ? 1'b0 : (sc == 0);
  assign ss_usable = nouse ? 1'b0 : (sc <= STORE);
  assign ss_full   = (sc >= STORE);
  assign ss_top    = (!nouse && sc > 0 && sc <= STORE) ? st[sc-1] : '0;

  typedef struct {
    bit            call;
    logic [DW-1:0] a;
  } ev_t;

  ev_t           mq[$];
  bit            m_viol;
  logic [DW-1:0] m_va;
  logic [DW-1:0] m_ve;
  int            m_cnt;

  int n_chk;
  int n_err;
  int n_pop;

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_viol = 0;
    m_va   = '0;
    m_ve   = '0;
    m_cnt  = 0;
    sc     = 0;
    nouse  = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn          = 1'b0;
    evt_valid     = '0;
    evt_is_call   = '0;
    a0_in         = '0;
    a1_in         = '0;
    clr_violation = 1'b0;
    #1;
    chk("rst_push", ss_push, 0);
    chk("rst_pop", ss_pop, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_viol", o_violation, 0);
    chk("rst_vaddr", o_viol_addr, 0);
    chk("rst_vexp", o_viol_exp, 0);
    chk("rst_cnt", o_viol_cnt, 0);
    model_clear();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // One clock: drive, check against model, then advance model and stack.
  task automatic cyc(input logic [1:0] v, input logic [1:0] c,
                     input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                     input bit clr, output bit acc);
    bit            e_ready;
    bit            e_push;
    bit            e_pop;
    bit            deq;
    bit            trapn;
    bit            vprev;
    logic [DW-1:0] nva;
    logic [DW-1:0] nve;
    ev_t           h;
    @(negedge clk);
    evt_valid     = v;
    evt_is_call   = c;
    a0_in         = a0;
    a1_in         = a1;
    clr_violation = clr;
    #1;
    e_ready = !m_viol && (QDEPTH - mq.size()) >= 2;
    e_push  = 0;
    e_pop   = 0;
    deq     = 0;
    trapn   = 0;
    nva     = '0;
    nve     = '0;
    h       = '{0, '0};
    if (!m_viol && mq.size() > 0) begin
      h   = mq[0];
      deq = 1;
      if (h.call) begin
        e_push = 1;
      end else if (!nouse && sc == 0) begin
`ifdef SS_CTRL_UNDERFLOW_TRAP_EN
        trapn = 1;
        nva   = h.a;
        nve   = '0;
`endif
      end else if (nouse || sc > STORE) begin
        e_pop = 1;
      end else begin
        e_pop = 1;
        if (st[sc-1] != h.a) begin
          trapn = 1;
          nva   = h.a;
          nve   = st[sc-1];
        end
      end
    end
    chk("ready", evt_ready, e_ready);
    chk("push", ss_push, e_push);
    chk("pop", ss_pop, e_pop);
    if (e_push) chk("data", ss_data, h.a);
    chk("viol", o_violation, m_viol);
    chk("vaddr", o_viol_addr, m_va);
    chk("vexp", o_viol_exp, m_ve);
    chk("vcnt", o_viol_cnt, DW'(m_cnt));
    chk("busy", o_busy, (mq.size() > 0) || m_viol);
    if (ss_pop) n_pop++;
    @(posedge clk);
    #1;
    if (e_push) begin
      if (sc < STORE) st[sc] = h.a;
      sc++;
    end
    if (e_pop && sc > 0) sc--;
    vprev = m_viol;
    if (deq) void'(mq.pop_front());
    if (trapn) begin
      m_viol = 1;
      m_va   = nva;
      m_ve   = nve;
      if (m_cnt < 255) m_cnt++;
    end else if (vprev && clr) begin
      m_viol = 0;
    end
    if (e_ready) begin
      if (v[0]) mq.push_back('{c[0], a0});
      if (v[1]) mq.push_back('{c[1], a1});
    end
    acc = e_ready;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(2'b00, 2'b00, '0, '0, 0, acc);
  endtask

  initial begin
    bit acc;
    int k;
    int guard;
    n_chk = 0;
    n_err = 0;
    n_pop = 0;
    rstn  = 1'b0;
    model_clear();

    // call then matching ret
    do_reset();
    cyc(2'b01, 2'b01, 64'h1004, '0, 0, acc);
    cyc(2'b01, 2'b00, 64'h1004, '0, 0, acc);
    idle(3);
    chk("d39_viol", o_violation, 0);

    // same-cycle call and ret
    cyc(2'b11, 2'b01, 64'h2000, 64'h2000, 0, acc);
    idle(3);
    chk("d40_viol", o_violation, 0);

    // mismatch
    do_reset();
    cyc(2'b01, 2'b01, 64'h3000, '0, 0, acc);
    cyc(2'b01, 2'b00, 64'h3008, '0, 0, acc);
    idle(3);
    chk("d41_viol", o_violation, 1);
    chk("d41_vaddr", o_viol_addr, 64'h3008);
    chk("d41_vexp", o_viol_exp, 64'h3000);
    chk("d41_cnt", o_viol_cnt, 1);
    chk("d41_ready", evt_ready, 0);
    cyc(2'b00, 2'b00, '0, '0, 1, acc);
    chk("d41_clr", o_violation, 0);
    chk("d41_rdy2", evt_ready, 1);

    // ret on empty stack
    do_reset();
    cyc(2'b01, 2'b00, 64'h40, '0, 0, acc);
    n_pop = 0;
    idle(3);
    chk("d42_pop", n_pop, 0);
`ifdef SS_CTRL_UNDERFLOW_TRAP_EN
    chk("d42_viol", o_violation, 1);
    chk("d42_vexp", o_viol_exp, 0);
    chk("d42_vaddr", o_viol_addr, 64'h40);
`else
    chk("d42_viol", o_violation, 0);
    chk("d42_cnt", o_viol_cnt, 0);
`endif

    // back-to-back dual rets beyond stack storage
    do_reset();
    nouse = 1;
    n_pop = 0;
    k     = 0;
    guard = 0;
    while (k < 5 && guard < 40) begin
      cyc(2'b11, 2'b00, DW'(256 + k * 16), DW'(264 + k * 16), 0, acc);
      if (acc) k++;
      guard++;
    end
    idle(10);
    chk("d43_pops", n_pop, 10);
    chk("d43_viol", o_violation, 0);

    // reset with three queued events
    do_reset();
    cyc(2'b11, 2'b11, 64'h500, 64'h504, 0, acc);
    cyc(2'b11, 2'b11, 64'h508, 64'h50c, 0, acc);
    chk("d44_busy0", o_busy, 1);
    do_reset();
    n_pop = 0;
    idle(3);
    chk("d44_pop", n_pop, 0);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [1:0]    v;
      logic [1:0]    c;
      logic [DW-1:0] ra0;
      logic [DW-1:0] ra1;
      bit            clr;
      v   = 2'($urandom_range(0, 3));
      c   = 2'($urandom_range(0, 3));
      ra0 = DW'(32'h1000 + 4 * $urandom_range(0, 2));
      ra1 = DW'(32'h1000 + 4 * $urandom_range(0, 2));
      clr = ($urandom_range(0, 3) == 0);
      cyc(v, c, ra0, ra1, clr, acc);
      if (i == 1500) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
